aes256_dec_round_ctrl: RTL
==========================

# aes256_dec_round_ctrl

Iterative AES-256 decryption engine controller: accepts one 128-bit ciphertext block, sequences it through the 14 inverse rounds (InvShiftRows, InverseSubByte, AddRoundKey, InvMixColumns) at one round per clock, and returns the plaintext. It owns the 128-bit state register and the round counter. It drives the round-key index to the key-expansion storage. It sits between the decryption top-level handshake and the combinational inverse-round datapath.

## Interface
Parameters:
- NR, 14, number of AES-256 rounds; fixed, not intended for override.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  ciphertext block offered.
- in_ready  out  1  controller can accept a block.
- in_data  in  128  ciphertext, byte 0 in [127:120].
- rk_idx  out  4  round-key index requested, 0..14.
- rk  in  128  round key for rk_idx, combinationally valid in the same cycle.
- out_valid  out  1  plaintext available.
- out_ready  in  1  consumer accepts plaintext.
- out_data  out  128  plaintext, same byte order as in_data.
- busy  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, ROUND, FINAL, DONE. Round counter rnd is 4 bits.
- IDLE:
  - in_ready=1 and rk_idx=14.
  - On in_valid&&in_ready: st <= in_data ^ rk, rnd <= 13, go to ROUND.
- ROUND:
  - rk_idx=rnd.
  - st <= InvMixColumns(InverseSubByte(InvShiftRows(st)) ^ rk).
  - If rnd==1, go to FINAL. Otherwise rnd <= rnd-1.
- FINAL:
  - rk_idx=0.
  - st <= InverseSubByte(InvShiftRows(st)) ^ rk.
  - Go to DONE.
- DONE:
  - out_valid=1 and out_data=st.
  - On out_ready: go to IDLE. st is not cleared.
- in_valid outside IDLE is ignored. in_ready=0 in ROUND, FINAL and DONE.
- rk_idx in DONE is 0. It is a don't-care for the key store but deterministic.
- All arithmetic is GF(2^8) or XOR. There are no carries. rnd never wraps, because FINAL is entered at rnd==1.

## Timing
- Reset values:
  - FSM=IDLE, rnd=0, st=0.
  - out_valid=0, busy=0, out_data=0.
  - in_ready=0 while rst is high, and 1 in the first cycle after rst deasserts.
- Latency: for input accepted at edge T, ROUND occupies cycles T+1..T+13, FINAL occupies T+14, and out_valid rises at T+15.
- Throughput with out_ready held at 1: one block per 16 cycles. The accept cycle in IDLE is separate from the DONE cycle. There is no same-cycle accept in DONE.
- Back-pressure: in DONE with out_ready=0, out_valid and out_data hold stable indefinitely.
- Reset mid-operation: any state returns to IDLE on the next edge. A partial block is discarded and no out_valid pulse follows.
- in_valid and rst both high in the same cycle: rst wins and nothing is accepted.
- Outputs are registered or decoded from the FSM only. No combinational path runs from in_valid or out_ready to any output.

## Structure
- Package aes_dec_pkg holds:
  - the FSM state enum (IDLE, ROUND, FINAL, DONE);
  - NR=14;
  - the round-key index width (4).
- Sub-module aes_inv_round is combinational. Inputs: st[127:0], rk[127:0], last. It computes InvShiftRows, then InverseSubByte (16 InverseSbox instances), then the XOR with rk, then InvMixColumns bypassed when last=1.
- The controller contains one aes_inv_round instance, the FSM, rnd, and st. The IDLE pre-whitening XOR is done in the controller.

## Test plan
- **FIPS-197 C.3 vector:** bench key store is expanded from key 000102..1f. Apply in_data=8ea2b7ca516745bfeafc49904b496089 -> out_data=00112233445566778899aabbccddeeff, out_valid at accept+15.
- **Key index sequence:** log rk_idx over one block -> exactly 14 (accept), 13, 12, …, 1, 0 on consecutive cycles.
- **Back-pressure:** hold out_ready=0 for 20 cycles after out_valid -> out_valid and out_data stable, in_ready=0 and in_valid ignored. Release -> in_ready=1 the next cycle.
- **Back-to-back:** in_valid and out_ready held high with two different FIPS-derived blocks -> both correct, accepts 16 cycles apart.
- **Reset mid-operation:** assert rst at accept+7 for one cycle -> IDLE, out_valid never asserts for that block. The next block decrypts correctly.
- **Reset/valid collision:** in_valid=1 during rst -> no accept, rnd=0, busy=0 after reset.

Source files
------------

// File: rtl/aes_dec_pkg.sv
// ----------------------------------------------------------------------------
// aes_dec_pkg
// Shared definitions for the iterative AES-256 decryption controller:
//   - NR            : number of AES-256 rounds (14)
//   - RK_IDX_W      : width of the round-key index driven to the key store
//   - dec_state_e   : controller FSM states (IDLE, ROUND, FINAL, DONE)
//   - gf_mul        : GF(2^8) multiply, AES polynomial x^8+x^4+x^3+x+1
//   - gf_inv        : GF(2^8) multiplicative inverse (0 maps to 0)
//   - inv_sbox      : AES inverse S-box built from the two functions above
// ----------------------------------------------------------------------------
package aes_dec_pkg;

    localparam int NR       = 14;
    localparam int RK_IDX_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_FINAL = 2'd2,
        ST_DONE  = 2'd3
    } dec_state_e;

    // Shift-and-add multiply; each step reduces by 0x1b when bit 7 falls out.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] aa;
        acc = 8'h00;
        aa  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                acc ^= aa;
            end
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return acc;
    endfunction

    // x^254 == x^-1 in GF(2^8); the addition chain keeps the depth short.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] x2, x3, x6, x7, x14, x15, x30, x31, x62, x63, x126, x127;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x6   = gf_mul(x3, x3);
        x7   = gf_mul(x6, x);
        x14  = gf_mul(x7, x7);
        x15  = gf_mul(x14, x);
        x30  = gf_mul(x15, x15);
        x31  = gf_mul(x30, x);
        x62  = gf_mul(x31, x31);
        x63  = gf_mul(x62, x);
        x126 = gf_mul(x63, x63);
        x127 = gf_mul(x126, x);
        return gf_mul(x127, x127);
    endfunction

    // Inverse S-box: undo the affine transform first, then invert in the field.
    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        logic [7:0] b;
        b = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
        return gf_inv(b);
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// ----------------------------------------------------------------------------
// aes_inv_round
// Combinational AES inverse round:
//   InvShiftRows -> InvSubBytes (16 inverse S-boxes) -> XOR round key
//   -> InvMixColumns (bypassed when last_i = 1)
// Byte 0 of every 128-bit word sits in [127:120]; byte k is state[row k%4]
// [column k/4].
// Ports:
//   st_i   [127:0] state entering the round
//   rk_i   [127:0] round key for this round
//   last_i         1 = final round, skip InvMixColumns
//   st_o   [127:0] state leaving the round
// ----------------------------------------------------------------------------
module aes_inv_round
    import aes_dec_pkg::*;
(
    input  logic [127:0] st_i,
    input  logic [127:0] rk_i,
    input  logic         last_i,
    output logic [127:0] st_o
);

    logic [7:0] sr  [16];
    logic [7:0] sb  [16];
    logic [7:0] ark [16];
    logic [7:0] mc  [16];

    // InvShiftRows: row r rotates right by r, so out[r][c] = in[r][(c-r) mod 4].
    for (genvar c = 0; c < 4; c++) begin : g_col_isr
        for (genvar r = 0; r < 4; r++) begin : g_row_isr
            assign sr[r + 4*c] = st_i[127 - 8*(r + 4*((c - r + 4) % 4)) -: 8];
        end
    end

    for (genvar i = 0; i < 16; i++) begin : g_byte
        assign sb[i]  = inv_sbox(sr[i]);
        assign ark[i] = sb[i] ^ rk_i[127 - 8*i -: 8];
        assign st_o[127 - 8*i -: 8] = last_i ? ark[i] : mc[i];
    end

    for (genvar c = 0; c < 4; c++) begin : g_col_imc
        assign mc[4*c+0] = gf_mul(ark[4*c+0], 8'h0e) ^ gf_mul(ark[4*c+1], 8'h0b)
                         ^ gf_mul(ark[4*c+2], 8'h0d) ^ gf_mul(ark[4*c+3], 8'h09);
        assign mc[4*c+1] = gf_mul(ark[4*c+0], 8'h09) ^ gf_mul(ark[4*c+1], 8'h0e)
                         ^ gf_mul(ark[4*c+2], 8'h0b) ^ gf_mul(ark[4*c+3], 8'h0d);
        assign mc[4*c+2] = gf_mul(ark[4*c+0], 8'h0d) ^ gf_mul(ark[4*c+1], 8'h09)
                         ^ gf_mul(ark[4*c+2], 8'h0e) ^ gf_mul(ark[4*c+3], 8'h0b);
        assign mc[4*c+3] = gf_mul(ark[4*c+0], 8'h0b) ^ gf_mul(ark[4*c+1], 8'h0d)
                         ^ gf_mul(ark[4*c+2], 8'h09) ^ gf_mul(ark[4*c+3], 8'h0e);
    end

endmodule

// File: rtl/aes256_dec_round_ctrl.sv
// ----------------------------------------------------------------------------
// aes256_dec_round_ctrl
// Iterative AES-256 decryption controller, one inverse round per clock.
// Owns the 128-bit state register and the round counter, drives the
// round-key index to the key store and sequences the inverse-round datapath.
//
// Handshakes (both sides): a transfer happens on a rising edge where valid
// and ready are both high. Once out_valid_o rises it stays high with
// out_data_o stable until out_ready_i is seen. in_ready_o is high only in
// IDLE while reset is low; in_valid_i in any other state is ignored.
//
// Ports:
//   clk_i         clock, rising edge
//   rst_i         synchronous active-high reset
//   in_valid_i    ciphertext offered
//   in_ready_o    block can be accepted (IDLE and not in reset)
//   in_data_i     ciphertext, byte 0 in [127:120]
//   rk_idx_o      round-key index requested (14 in IDLE, rnd in ROUND, else 0)
//   rk_i          round key for rk_idx_o, valid in the same cycle
//   out_valid_o   plaintext available (DONE)
//   out_ready_i   consumer takes plaintext
//   out_data_o    plaintext, same byte order; zero outside DONE
//   busy_o        FSM not in IDLE
//   dbg_state_o   current FSM state
//   dbg_rnd_o     current round counter
// ----------------------------------------------------------------------------
module aes256_dec_round_ctrl
    import aes_dec_pkg::*;
#(
    parameter int NR = aes_dec_pkg::NR
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [127:0]        in_data_i,
    output logic [RK_IDX_W-1:0] rk_idx_o,
    input  logic [127:0]        rk_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [127:0]        out_data_o,
    output logic                busy_o,
    output dec_state_e          dbg_state_o,
    output logic [RK_IDX_W-1:0] dbg_rnd_o
);

    dec_state_e          state_q, state_d;
    logic [RK_IDX_W-1:0] rnd_q, rnd_d;
    logic [127:0]        st_q, st_d;
    logic [RK_IDX_W-1:0] rk_idx_q, rk_idx_d;
    logic                out_valid_q, out_valid_d;
    logic                busy_q, busy_d;

    logic [127:0] round_out;
    logic         last_round;

    assign last_round = (state_q == ST_FINAL);

    aes_inv_round u_inv_round (
        .st_i   (st_q),
        .rk_i   (rk_i),
        .last_i (last_round),
        .st_o   (round_out)
    );

    always_comb begin
        state_d     = state_q;
        rnd_d       = rnd_q;
        st_d        = st_q;
        rk_idx_d    = rk_idx_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;

        unique case (state_q)
            ST_IDLE: begin
                // Pre-whitening with the last round key (rk_idx = NR here).
                if (in_valid_i) begin
                    st_d    = in_data_i ^ rk_i;
                    rnd_d   = RK_IDX_W'(NR - 1);
                    state_d = ST_ROUND;
                end
            end
            ST_ROUND: begin
                st_d = round_out;
                // Leaving at rnd==1 means the counter never wraps below 1.
                if (rnd_q == RK_IDX_W'(1)) begin
                    state_d = ST_FINAL;
                end else begin
                    rnd_d = rnd_q - RK_IDX_W'(1);
                end
            end
            ST_FINAL: begin
                st_d    = round_out;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                // st is kept; only the state leaves DONE.
                if (out_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered from the next state so that rk_idx_o is
        // already correct in the cycle the datapath consumes rk_i.
        unique case (state_d)
            ST_IDLE:  rk_idx_d = RK_IDX_W'(NR);
            ST_ROUND: rk_idx_d = rnd_d;
            default:  rk_idx_d = '0;
        endcase
        out_valid_d = (state_d == ST_DONE);
        busy_d      = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            rnd_q       <= '0;
            st_q        <= '0;
            rk_idx_q    <= RK_IDX_W'(NR);
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rnd_q       <= rnd_d;
            st_q        <= st_d;
            rk_idx_q    <= rk_idx_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    // Gated with rst_i so the block does not advertise readiness while the
    // reset is still being held, even though the state is already IDLE.
    assign in_ready_o  = (state_q == ST_IDLE) && !rst_i;
    assign rk_idx_o    = rk_idx_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_valid_q ? st_q : '0;
    assign busy_o      = busy_q;
    assign dbg_state_o = state_q;
    assign dbg_rnd_o   = rnd_q;

endmodule
